// File: rtl/vertex_project.sv
// Perspective divide of a Q8.8 vertex: x' = x/z and y' = y/z, with z passed through.
// A single restoring divider yields one quotient bit per cycle and is shared between x and y.
module vertex_project (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_vertex,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_vertex,
  output logic        out_div_zero
);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t      state_q, state_d;
  logic [47:0] vtx_q, vtx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [23:0] dvd_q, dvd_d;
  logic [15:0] xres_q, xres_d;
  logic [47:0] out_vertex_q, out_vertex_d;
  logic        dz_q, dz_d;

  logic [15:0] div_mag;
  logic [16:0] r_sh;
  logic [17:0] diff;
  logic        q_bit;
  logic [15:0] rem_nxt;
  logic [23:0] dvd_nxt;
  logic        last;

  // Magnitude of a signed Q8.8 value; |-128.0| = 0x8000 still fits in 16 unsigned bits.
  function automatic logic [15:0] mag(input logic [15:0] v);
    mag = v[15] ? (16'h0000 - v) : v;
  endfunction

  function automatic logic [15:0] sat_q(input logic [23:0] q, input logic neg);
    if (neg) sat_q = (q >= 24'h008000) ? 16'h8000 : (16'h0000 - q[15:0]);
    else     sat_q = (q >  24'h007FFF) ? 16'h7FFF : q[15:0];
  endfunction

  function automatic logic [15:0] sat_zero(input logic [15:0] n);
    sat_zero = n[15] ? 16'h8000 : 16'h7FFF;
  endfunction

  // One restoring-division step: the dividend shifts out MSB first and quotient bits shift in.
  always_comb begin
    div_mag = mag(vtx_q[15:0]);
    r_sh    = {rem_q, dvd_q[23]};
    diff    = {1'b0, r_sh} - {2'b00, div_mag};
    q_bit   = ~diff[17];
    rem_nxt = q_bit ? diff[15:0] : r_sh[15:0];
    dvd_nxt = {dvd_q[22:0], q_bit};
    last    = (cnt_q == 5'd23);
  end

  always_comb begin
    state_d      = state_q;
    vtx_d        = vtx_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    dvd_d        = dvd_q;
    xres_d       = xres_q;
    out_vertex_d = out_vertex_q;
    dz_d         = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vtx_d = in_vertex;
          cnt_d = 5'd0;
          rem_d = 16'h0000;
          if (in_vertex[15:0] == 16'h0000) begin
            out_vertex_d = {sat_zero(in_vertex[47:32]), sat_zero(in_vertex[31:16]), 16'h0000};
            dz_d         = 1'b1;
            state_d      = DONE;
          end else begin
            dvd_d   = {mag(in_vertex[47:32]), 8'h00};
            dz_d    = 1'b0;
            state_d = DIV_X;
          end
        end
      end
      DIV_X: begin
        rem_d = rem_nxt;
        dvd_d = dvd_nxt;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          xres_d  = sat_q(dvd_nxt, vtx_q[47] ^ vtx_q[15]);
          rem_d   = 16'h0000;
          cnt_d   = 5'd0;
          dvd_d   = {mag(vtx_q[31:16]), 8'h00};
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        rem_d = rem_nxt;
        dvd_d = dvd_nxt;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          out_vertex_d = {xres_q, sat_q(dvd_nxt, vtx_q[31] ^ vtx_q[15]), vtx_q[15:0]};
          cnt_d        = 5'd0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    vtx_q  <= vtx_d;
    rem_q  <= rem_d;
    dvd_q  <= dvd_d;
    xres_q <= xres_d;
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      out_vertex_q <= 48'h0;
      dz_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_vertex_q <= out_vertex_d;
      dz_q         <= dz_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_vertex   = out_vertex_q;
  assign out_div_zero = dz_q;

endmodule
